// File: rtl/sensor_conditioner.sv
// sensor_conditioner: input stage for the vehicle access controller.
// Takes the two raw gate photo-sensor lines, synchronises each one to clk
// with two flops and debounces it on its own. Outputs are the clean levels
// a/b and a one-cycle pulse for each clean rising or falling edge.
// Ports:
//   clk            system clock; all state changes on the rising edge
//   reset          asynchronous active-high reset; clears all state
//   a_raw, b_raw   raw sensor lines (outer / inner beam), asynchronous to clk
//   a, b           debounced levels (registered)
//   a_rise, a_fall one-cycle pulses when a goes 0->1 / 1->0 (registered)
//   b_rise, b_fall one-cycle pulses when b goes 0->1 / 1->0 (registered)
module sensor_conditioner #(
  parameter int unsigned DB_COUNT = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic a_raw,
  input  logic b_raw,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
);

  localparam int unsigned N_CH = 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);

  // Bit 0 is channel A, bit 1 is channel B.
  logic [N_CH-1:0]  raw_vec;
  logic [N_CH-1:0]  sync1;
  logic [N_CH-1:0]  sync2;
  logic [N_CH-1:0]  stable;
  logic [N_CH-1:0]  rise_q;
  logic [N_CH-1:0]  fall_q;
  logic [CNT_W-1:0] cnt [N_CH];
  logic [N_CH-1:0]  differ_c;
  logic [N_CH-1:0]  accept_c;

  assign raw_vec = {b_raw, a_raw};

  // Per-channel: does the synchronised level disagree with the clean level,
  // and has it done so for DB_COUNT consecutive samples (including this one)?
  always_comb begin
    differ_c = '0;
    accept_c = '0;
    for (int i = 0; i < N_CH; i++) begin
      differ_c[i] = sync2[i] ^ stable[i];
      accept_c[i] = differ_c[i] && (cnt[i] == CNT_LAST);
    end
  end

  // Synchroniser, debounce counters, clean level and edge pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      rise_q <= '0;
      fall_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1  <= raw_vec;
      sync2  <= sync1;
      stable <= stable ^ accept_c;
      rise_q <= accept_c & sync2;
      fall_q <= accept_c & ~sync2;
      for (int i = 0; i < N_CH; i++) begin
        // Any agreeing sample, or an accepted change, restarts the count.
        if (!differ_c[i] || accept_c[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign a      = stable[0];
  assign b      = stable[1];
  assign a_rise = rise_q[0];
  assign a_fall = fall_q[0];
  assign b_rise = rise_q[1];
  assign b_fall = fall_q[1];

endmodule
